// File: rtl/drm_activator_license_responder.sv
// drm_activator_license_responder: DRM bus target that validates a 4-word license frame,
// latches the activation code on a product-ID match and exposes a 64-bit usage meter.
module drm_activator_license_responder #(
    parameter logic [63:0] PRODUCT_ID     = 64'h1042000100010001,
    parameter bit          METER_SATURATE = 1'b1,
    parameter logic [63:0] METER_RESET    = 64'd0
) (
    input  logic        DRM_ACLK,
    input  logic        DRM_ARST,
    input  logic        DRM_BUS_SLAVE_I_CS,
    input  logic        DRM_BUS_SLAVE_I_CYC,
    input  logic        DRM_BUS_SLAVE_I_WE,
    input  logic [1:0]  DRM_BUS_SLAVE_I_ADR,
    input  logic [31:0] DRM_BUS_SLAVE_I_DAT,
    output logic        DRM_BUS_SLAVE_O_ACK,
    output logic        DRM_BUS_SLAVE_O_STA,
    output logic        DRM_BUS_SLAVE_O_INTR,
    output logic [31:0] DRM_BUS_SLAVE_O_DAT,
    output logic        ip_activation_code_ready,
    output logic [63:0] ip_activation_code,
    input  logic        ip_metering_event
);
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    state_t state, state_nx;
    logic        start, illegal, lic_wr, ctrl_wr, word3, revoke, mismatch, fail, err;
    logic        we_l;
    logic [1:0]  adr_l, wcnt;
    logic [31:0] dat_l, code_hi, rd_mux, rdata, meter_hi_shadow, pid_word;
    logic [63:0] meter, meter_inc;
    assign start    = state == IDLE && DRM_BUS_SLAVE_I_CS && DRM_BUS_SLAVE_I_CYC;
    assign illegal  = DRM_BUS_SLAVE_I_WE ? DRM_BUS_SLAVE_I_ADR[1] : DRM_BUS_SLAVE_I_ADR == 2'd0;
    assign rd_mux   = DRM_BUS_SLAVE_I_ADR == 2'd1 ? {28'b0, ip_activation_code_ready, err, wcnt} :
                      DRM_BUS_SLAVE_I_ADR == 2'd2 ? meter[31:0] :
                      DRM_BUS_SLAVE_I_ADR == 2'd3 ? meter_hi_shadow : 32'd0;
    assign rdata    = (DRM_BUS_SLAVE_I_WE || illegal) ? 32'd0 : rd_mux;
    // Side effects use the request captured at sampling time, not the live bus.
    assign lic_wr   = state == ACK && we_l && adr_l == 2'd0;
    assign ctrl_wr  = state == ACK && we_l && adr_l == 2'd1;
    assign word3    = lic_wr && wcnt == 2'd3;
    assign revoke   = ctrl_wr && dat_l[2];
    assign pid_word = wcnt[0] ? PRODUCT_ID[31:0] : PRODUCT_ID[63:32];
    assign mismatch = dat_l != pid_word;
    assign meter_inc = (METER_SATURATE && &meter) ? meter : meter + 64'd1;
    always_comb begin
        state_nx = state;
        if (start)
            state_nx = ACK;
        else if (state == ACK)
            state_nx = HOLD;
        else if (state == HOLD && !DRM_BUS_SLAVE_I_CYC)
            state_nx = IDLE;
    end
    always_ff @(posedge DRM_ACLK or posedge DRM_ARST) begin
        if (DRM_ARST)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge DRM_ACLK or posedge DRM_ARST) begin
        if (DRM_ARST) begin
            DRM_BUS_SLAVE_O_ACK <= 1'b0;
            DRM_BUS_SLAVE_O_STA <= 1'b0;
            DRM_BUS_SLAVE_O_DAT <= 32'd0;
            we_l                <= 1'b0;
            adr_l               <= 2'd0;
            dat_l               <= 32'd0;
            meter_hi_shadow     <= 32'd0;
        end else begin
            DRM_BUS_SLAVE_O_ACK <= start;
            DRM_BUS_SLAVE_O_STA <= start && illegal;
            DRM_BUS_SLAVE_O_DAT <= start ? rdata : 32'd0;
            if (start) begin
                we_l  <= DRM_BUS_SLAVE_I_WE;
                adr_l <= DRM_BUS_SLAVE_I_ADR;
                dat_l <= DRM_BUS_SLAVE_I_DAT;
            end
            if (start && !DRM_BUS_SLAVE_I_WE && DRM_BUS_SLAVE_I_ADR == 2'd2)
                meter_hi_shadow <= meter[63:32];
        end
    end
    always_ff @(posedge DRM_ACLK or posedge DRM_ARST) begin
        if (DRM_ARST) begin
            wcnt                     <= 2'd0;
            fail                     <= 1'b0;
            err                      <= 1'b0;
            code_hi                  <= 32'd0;
            ip_activation_code       <= 64'd0;
            ip_activation_code_ready <= 1'b0;
            DRM_BUS_SLAVE_O_INTR     <= 1'b0;
        end else begin
            DRM_BUS_SLAVE_O_INTR <= word3;
            if (lic_wr) begin
                wcnt <= wcnt + 2'd1;
                if (wcnt == 2'd0)
                    fail <= mismatch;
                else if (wcnt == 2'd1)
                    fail <= fail | mismatch;
                if (wcnt == 2'd2)
                    code_hi <= dat_l;
                if (word3) begin
                    ip_activation_code_ready <= !fail;
                    err                      <= err | fail;
                    if (!fail)
                        ip_activation_code <= {code_hi, dat_l};
                end
            end
            if (ctrl_wr) begin
                if (dat_l[0])
                    wcnt <= 2'd0;
                if (dat_l[1])
                    err <= 1'b0;
                if (dat_l[2]) begin
                    ip_activation_code_ready <= 1'b0;
                    ip_activation_code       <= 64'd0;
                end
            end
        end
    end
    // An event coinciding with a revoke is dropped, matching the post-revoke view.
    always_ff @(posedge DRM_ACLK or posedge DRM_ARST) begin
        if (DRM_ARST)
            meter <= METER_RESET;
        else if (ip_activation_code_ready && ip_metering_event && !revoke)
            meter <= meter_inc;
    end
endmodule

// File: tb/tb_drm_activator_license_responder.sv
// tb_drm_activator_license_responder: directed bus transactions with a queue-based response scoreboard;
// a second instance preloaded near all-ones shares the stimulus to exercise meter saturation.
module tb_drm_activator_license_responder;
    logic        clk = 1'b0, rst = 1'b1, cs = 1'b0, cyc = 1'b0, we = 1'b0, ev = 1'b0;
    logic [1:0]  adr = 2'd0;
    logic [31:0] wdat = 32'd0;
    logic        ack, sta, intr, ready;
    logic [31:0] dat;
    logic [63:0] code;
    logic        ack2, sta2, intr2, ready2;
    logic [31:0] dat2;
    logic [63:0] code2;
    int tests = 0, fails = 0, acks = 0, intrs = 0, lat;
    typedef struct {
        logic [31:0] dat;
        logic        sta;
        logic [31:0] dat2;
        logic        chk2;
    } exp_t;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    drm_activator_license_responder dut (
        .DRM_ACLK(clk), .DRM_ARST(rst), .DRM_BUS_SLAVE_I_CS(cs), .DRM_BUS_SLAVE_I_CYC(cyc),
        .DRM_BUS_SLAVE_I_WE(we), .DRM_BUS_SLAVE_I_ADR(adr), .DRM_BUS_SLAVE_I_DAT(wdat),
        .DRM_BUS_SLAVE_O_ACK(ack), .DRM_BUS_SLAVE_O_STA(sta), .DRM_BUS_SLAVE_O_INTR(intr),
        .DRM_BUS_SLAVE_O_DAT(dat), .ip_activation_code_ready(ready), .ip_activation_code(code),
        .ip_metering_event(ev)
    );
    drm_activator_license_responder #(.METER_RESET(64'hFFFF_FFFF_FFFF_FFFE)) dut_sat (
        .DRM_ACLK(clk), .DRM_ARST(rst), .DRM_BUS_SLAVE_I_CS(cs), .DRM_BUS_SLAVE_I_CYC(cyc),
        .DRM_BUS_SLAVE_I_WE(we), .DRM_BUS_SLAVE_I_ADR(adr), .DRM_BUS_SLAVE_I_DAT(wdat),
        .DRM_BUS_SLAVE_O_ACK(ack2), .DRM_BUS_SLAVE_O_STA(sta2), .DRM_BUS_SLAVE_O_INTR(intr2),
        .DRM_BUS_SLAVE_O_DAT(dat2), .ip_activation_code_ready(ready2), .ip_activation_code(code2),
        .ip_metering_event(ev)
    );

    always @(negedge clk) begin
        if (intr)
            intrs++;
        if (ack) begin
            acks++;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack: dat %h sta %b with nothing expected", dat, sta);
            end else begin
                e = q.pop_front();
                if ({sta, dat} !== {e.sta, e.dat}) begin
                    fails++;
                    $display("FAIL bus_response: got sta %b dat %h, expected sta %b dat %h", sta, dat, e.sta, e.dat);
                end
                if (e.chk2) begin
                    tests++;
                    if (dat2 !== e.dat2) begin
                        fails++;
                        $display("FAIL sat_meter_read: got %h, expected %h", dat2, e.dat2);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d,
                          input logic [31:0] ed, input logic es, input logic [31:0] ed2,
                          input logic c2);
        exp_t x;
        x = '{dat: ed, sta: es, dat2: ed2, chk2: c2};
        q.push_back(x);
        @(negedge clk);
        cs = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 8);
        if (!ack) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: no ack after %0d cycles, expected 1", lat);
            void'(q.pop_back());
        end
        cs = 1'b0; cyc = 1'b0; we = 1'b0; adr = 2'd0; wdat = 32'd0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic es = 1'b0);
        access(1'b1, a, d, 32'd0, es, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] ed, input logic es = 1'b0);
        access(1'b0, a, 32'd0, ed, es, 32'd0, 1'b0);
    endtask

    task automatic rd2(input logic [1:0] a, input logic [31:0] ed, input logic [31:0] ed2);
        access(1'b0, a, 32'd0, ed, 1'b0, ed2, 1'b1);
    endtask

    task automatic frame(input logic [31:0] w1);
        wr(2'd0, 32'h10420001);
        wr(2'd0, w1);
        wr(2'd0, 32'hDEADBEEF);
        wr(2'd0, 32'h01234567);
        @(negedge clk);
    endtask

    task automatic events(input int n);
        @(negedge clk);
        ev = 1'b1;
        repeat (n) @(negedge clk);
        ev = 1'b0;
    endtask

    initial begin
        int a0, i0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {31'd0, ack, sta, intr, ready}, 64'd0);
        check("reset_dat", {32'd0, dat}, 64'd0);
        check("reset_code", code, 64'd0);
        rst = 1'b0;
        rd(2'd1, 32'h0);
        check("ack_latency", lat, 64'd1);

        i0 = intrs;
        frame(32'h00010001);
        check("valid_intr_pulses", intrs - i0, 64'd1);
        check("valid_ready", {63'd0, ready}, 64'd1);
        check("valid_code", code, 64'hDEADBEEF01234567);
        rd(2'd1, 32'h8);

        i0 = intrs;
        frame(32'h00010002);
        check("bad_intr_pulses", intrs - i0, 64'd1);
        check("bad_ready", {63'd0, ready}, 64'd0);
        rd(2'd1, 32'h4);
        wr(2'd0, 32'h10420001);
        rd(2'd1, 32'h5);
        wr(2'd1, 32'h1);
        rd(2'd1, 32'h4);
        wr(2'd1, 32'h2);
        rd(2'd1, 32'h0);

        frame(32'h00010001);
        check("relicense_ready", {63'd0, ready}, 64'd1);
        events(5);
        rd2(2'd2, 32'd5, 32'hFFFFFFFF);
        rd2(2'd3, 32'd0, 32'hFFFFFFFF);
        wr(2'd1, 32'h4);
        check("revoke_ready", {63'd0, ready}, 64'd0);
        check("revoke_code", code, 64'd0);
        events(2);
        rd2(2'd2, 32'd5, 32'hFFFFFFFF);
        rd(2'd0, 32'd0, 1'b1);
        wr(2'd2, 32'hFFFFFFFF, 1'b1);
        wr(2'd3, 32'h00000007, 1'b1);
        rd(2'd1, 32'h0);

        e = '{dat: 32'h0, sta: 1'b0, dat2: 32'h0, chk2: 1'b0};
        q.push_back(e);
        a0 = acks;
        @(negedge clk);
        cs = 1'b1; cyc = 1'b1; we = 1'b0; adr = 2'd1;
        repeat (10) @(negedge clk);
        cs = 1'b0; cyc = 1'b0; adr = 2'd0;
        repeat (2) @(negedge clk);
        check("stuck_cyc_acks", acks - a0, 64'd1);

        wr(2'd0, 32'h10420001);
        wr(2'd0, 32'h00010001);
        wr(2'd0, 32'hDEADBEEF);
        rd(2'd1, 32'h3);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_ready", {63'd0, ready}, 64'd0);
        rst = 1'b0;
        rd(2'd1, 32'h0);
        frame(32'h00010001);
        check("post_reset_ready", {63'd0, ready}, 64'd1);
        check("post_reset_code", code, 64'hDEADBEEF01234567);
        rd(2'd1, 32'h8);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/drm_activator_license_responder.md
# drm_activator_license_responder

Activator-side responder on the DRM bus: the target that the DRM Controller (or the simulation Controller BFM) addresses when unlocking an IP. Accepts a 4-word license frame and checks it against the product ID. On a match it latches the 64-bit activation code, asserts `ip_activation_code_ready` and raises an interrupt pulse. It also exposes a 64-bit metering counter for the controller to read back.

## Interface
- `PRODUCT_ID`, default `64'h1042000100010001`: product identifier the license frame must carry.
- `METER_SATURATE`, default `1`: meter behaviour at all-ones; `1` = hold at all-ones, `0` = wrap to 0.
- `DRM_ACLK`  in  1  clock; every flop is on the rising edge.
- `DRM_ARST`  in  1  asynchronous, active-high reset.
- `DRM_BUS_SLAVE_I_CS`  in  1  chip select.
- `DRM_BUS_SLAVE_I_CYC`  in  1  cycle valid; held by the initiator until ack.
- `DRM_BUS_SLAVE_I_WE`  in  1  1 = write, 0 = read.
- `DRM_BUS_SLAVE_I_ADR`  in  2  register address.
- `DRM_BUS_SLAVE_I_DAT`  in  32  write data.
- `DRM_BUS_SLAVE_O_ACK`  out  1  one-cycle acknowledge.
- `DRM_BUS_SLAVE_O_STA`  out  1  access error; valid only with ack.
- `DRM_BUS_SLAVE_O_INTR`  out  1  one-cycle pulse when a frame completes, pass or fail.
- `DRM_BUS_SLAVE_O_DAT`  out  32  read data; valid with ack, 0 otherwise.
- `ip_activation_code_ready`  out  1  license accepted.
- `ip_activation_code`  out  64  accepted activation code.
- `ip_metering_event`  in  1  one usage event per cycle high.

## Operation
- Register map:
  - Address 0, write: `LICENSE` word. Word index `wcnt` 0..3: words 0 and 1 are `PRODUCT_ID[63:32]` and `PRODUCT_ID[31:0]`; words 2 and 3 are activation code high and low.
  - Address 1, read: `STATUS` = `{28'b0, ready, err, wcnt[1:0]}`.
  - Address 1, write: `CTRL`. Bit0 aborts the frame (`wcnt`←0). Bit1 clears `err`. Bit2 revokes: `ready`←0 and `ip_activation_code`←0.
  - Address 2, read: meter bits [31:0]. The same access snapshots bits [63:32] into `meter_hi_shadow`.
  - Address 3, read: `meter_hi_shadow`.
- Illegal accesses: a read of address 0, or a write to address 2 or 3. These are acked with `O_STA`=1, have no side effect and return `O_DAT`=0.
- Frame check:
  - Any mismatch on word 0 or word 1 sets a frame-fail flag.
  - On word 3: if no fail, `ip_activation_code`←{w2,w3} and `ready`←1. Otherwise `err`←1 and `ready`←0.
  - `O_INTR` pulses on word 3 in both cases; `wcnt`←0.
  - `wcnt` wraps 3→0. The fail flag clears at word 0.
- Meter:
  - 64-bit counter, reset 0.
  - Increments on `ip_metering_event` only while `ready`=1.
  - At all-ones it follows `METER_SATURATE`.
  - A revoke does not clear the meter.
- Bus FSM:
  - `IDLE`: CS&CYC → `ACK`.
  - `ACK`: drive `O_ACK`=1 for one cycle and perform the register side effect here → `HOLD`.
  - `HOLD`: stay until CYC=0 → `IDLE`.
  - Exactly one ack per CYC assertion. A stuck CYC never produces a second ack.
  - CS=0 with CYC=1 is ignored; stay in `IDLE`.

## Timing
- Reset values:
  - All outputs are 0: `O_ACK`, `O_STA`, `O_INTR`, `O_DAT`, `ip_activation_code_ready`, `ip_activation_code`.
  - `wcnt`=0, `err`=0, meter=0, FSM=`IDLE`.
- Latency:
  - Request sampled in cycle N → `O_ACK` in cycle N+1.
  - Register updates become visible in cycle N+2.
  - `ready` and `O_INTR` become 1 in cycle N+2 relative to the word-3 request in cycle N. `ready` and `O_INTR` are both registered.
- Read data is registered and presented in the ack cycle.
- Minimum initiator spacing: CYC low for at least 1 cycle between transfers (throughput 1 access / 3 cycles).
- Meter read in the same cycle as `ip_metering_event`: returns the pre-increment value.
- Revoke in the same cycle as a metering event: that event is not counted.
- A `CTRL` abort hitting while a frame is open discards the partial frame. `err` is unchanged.
- `DRM_ARST` mid-transaction:
  - Immediate return to reset values.
  - No ack is issued for the interrupted access.
  - The initiator must re-issue after reset is released.

## Test plan
- Reset, then read `STATUS` → ack after 1 cycle, `O_DAT`=0, `O_STA`=0; every output was 0 during reset.
- Write words 0x10420001, 0x00010001, 0xDEADBEEF, 0x01234567 → `O_INTR` one pulse, `ip_activation_code`=64'hDEADBEEF01234567, `STATUS`=0x8.
- Same frame with word 1 = 0x00010002 → `O_INTR` pulses, `ready` stays 0, `STATUS`=0x4; write `CTRL`=0x2 → `STATUS`=0x0.
- After a valid license, pulse `ip_metering_event` 5 times, then read address 2 and address 3 → 5 and 0. Preload the meter to all-ones−1 and apply 3 events → reads all-ones (saturate).
- Hold CYC high for 10 cycles on a `STATUS` read → exactly one `O_ACK`. Read address 0 → `O_STA`=1, `O_DAT`=0, no state change.
- Assert `DRM_ARST` after word 2 of a frame → `wcnt`=0, `ready`=0. A full valid frame after release unlocks normally.
